// File: rtl/icache_ro.sv
// Read-only direct-mapped instruction cache with 4-word lines.
// Hits are served combinationally; a miss stalls the requester while one line is refilled.
module icache_ro #(
   parameter int NUM_SETS = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          proc_read,
   input  logic          proc_write,
   input  logic [29:0]   proc_addr,
   input  logic [31:0]   proc_wdata,
   output logic [31:0]   proc_rdata,
   output logic          proc_stall,
   output logic          mem_read,
   output logic          mem_write,
   output logic [27:0]   mem_addr,
   output logic [127:0]  mem_wdata,
   input  logic [127:0]  mem_rdata,
   input  logic          mem_ready
);

   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int TAG_W = 28 - IDX_W;

   typedef enum logic {
      S_IDLE,
      S_FILL
   } state_t;

   state_t              state_q, state_d;
   logic                mem_read_q, mem_read_d;
   logic [27:0]         mem_addr_q, mem_addr_d;
   logic [NUM_SETS-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]    tag_q  [NUM_SETS];
   logic [127:0]        data_q [NUM_SETS];

   logic [IDX_W-1:0]    req_idx;
   logic [TAG_W-1:0]    req_tag;
   logic [1:0]          req_word;
   logic [IDX_W-1:0]    fill_idx;
   logic [TAG_W-1:0]    fill_tag;
   logic [127:0]        req_line;
   logic                hit;
   logic                install;

   assign req_word = proc_addr[1:0];
   assign req_idx  = proc_addr[IDX_W+1:2];
   assign req_tag  = proc_addr[29:IDX_W+2];
   assign fill_idx = mem_addr_q[IDX_W-1:0];
   assign fill_tag = mem_addr_q[27:IDX_W];

   assign req_line   = data_q[req_idx];
   assign hit        = proc_read & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
   assign proc_rdata = req_line[{req_word, 5'b0} +: 32];

   assign mem_read  = mem_read_q;
   assign mem_addr  = mem_addr_q;
   assign mem_write = 1'b0;
   assign mem_wdata = '0;

   // Write path is never used by a read-only cache.
   logic unused_inputs;
   assign unused_inputs = ^{proc_write, proc_wdata};

   always_comb begin
      state_d    = state_q;
      mem_read_d = mem_read_q;
      mem_addr_d = mem_addr_q;
      proc_stall = 1'b0;
      install    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (proc_read && !hit) begin
               proc_stall = 1'b1;
               state_d    = S_FILL;
               mem_read_d = 1'b1;
               mem_addr_d = proc_addr[29:2];
            end
         end
         S_FILL: begin
            // The latched line is installed even if the requester has moved on.
            proc_stall = 1'b1;
            if (mem_ready) begin
               install    = 1'b1;
               mem_read_d = 1'b0;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      valid_d = valid_q;
      if (install) begin
         valid_d[fill_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         mem_read_q <= 1'b0;
         mem_addr_q <= '0;
         valid_q    <= '0;
      end else begin
         state_q    <= state_d;
         mem_read_q <= mem_read_d;
         mem_addr_q <= mem_addr_d;
         valid_q    <= valid_d;
      end
   end

   // Tag and data arrays carry no reset; a line only becomes visible through valid_q.
   always_ff @(posedge clk) begin
      if (rst_n && install) begin
         tag_q[fill_idx]  <= fill_tag;
         data_q[fill_idx] <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_icache_ro.sv
// Randomized bench for icache_ro: a transparent-memory reference model predicts every
// cycle's outputs, and a monitor compares them against the design from a queue.
module tb_icache_ro;

   localparam int NS = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          proc_read = 1'b0;
   logic          proc_write = 1'b0;
   logic [29:0]   proc_addr = '0;
   logic [31:0]   proc_wdata = '0;
   logic [31:0]   proc_rdata;
   logic          proc_stall;
   logic          mem_read;
   logic          mem_write;
   logic [27:0]   mem_addr;
   logic [127:0]  mem_wdata;
   logic [127:0]  mem_rdata = '0;
   logic          mem_ready = 1'b0;

   icache_ro #(.NUM_SETS(NS)) dut (
      .clk(clk), .rst_n(rst_n),
      .proc_read(proc_read), .proc_write(proc_write), .proc_addr(proc_addr),
      .proc_wdata(proc_wdata), .proc_rdata(proc_rdata), .proc_stall(proc_stall),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          stall;
      bit          chk_data;
      logic [31:0] rdata;
      bit          mrd;
      logic [27:0] maddr;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: the cache must look like the backing memory, with a set of
   // resident blocks (one per index) and at most one outstanding refill.
   bit          resident[logic [27:0]];
   bit          in_fill = 1'b0;
   logic [27:0] fill_blk = '0;
   logic [27:0] exp_maddr = '0;
   int          lat_cnt = 0;
   int          lat_cfg = 3;
   bit          idle_noise = 1'b0;
   bit          cur_rst = 1'b0;
   bit          cur_rd = 1'b0;
   bit          cur_ready = 1'b0;
   logic [29:0] cur_addr = '0;

   function automatic logic [31:0] mem_word(input logic [27:0] b, input int k);
      return (32'(b) * 32'h9E37_79B1) ^ (32'(k) << 28) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [127:0] mem_line(input logic [27:0] b);
      return {mem_word(b, 3), mem_word(b, 2), mem_word(b, 1), mem_word(b, 0)};
   endfunction

   function automatic void install_blk(input logic [27:0] b);
      logic [27:0] victims[$];
      foreach (resident[k]) begin
         if ((k % NS) == (b % NS)) victims.push_back(k);
      end
      foreach (victims[i]) resident.delete(victims[i]);
      resident[b] = 1'b1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("proc_stall", 32'(proc_stall), 32'(e.stall));
         if (e.chk_data) check("proc_rdata", proc_rdata, e.rdata);
         check("mem_read", 32'(mem_read), 32'(e.mrd));
         check("mem_addr", 32'(mem_addr), 32'(e.maddr));
         check("mem_write", 32'(mem_write), 32'd0);
         check("mem_wdata_nonzero", 32'(|mem_wdata), 32'd0);
      end
   end

   task automatic cycle(input bit rst, input bit rd, input logic [29:0] addr);
      exp_t e;
      bit   rdy;
      @(posedge clk);
      if (!cur_rst) begin
         resident.delete();
         in_fill   = 1'b0;
         exp_maddr = '0;
      end else if (in_fill) begin
         if (cur_ready) begin
            install_blk(fill_blk);
            in_fill = 1'b0;
         end
      end else if (cur_rd && !resident.exists(cur_addr[29:2])) begin
         in_fill   = 1'b1;
         fill_blk  = cur_addr[29:2];
         exp_maddr = fill_blk;
         lat_cnt   = lat_cfg;
      end
      #1;
      if (in_fill) begin
         rdy = (lat_cnt == 0);
         if (lat_cnt > 0) lat_cnt--;
      end else begin
         rdy = idle_noise && ($urandom % 6 == 0);
      end
      rst_n      = rst;
      proc_read  = rd;
      proc_addr  = addr;
      proc_write = 1'($urandom);
      proc_wdata = $urandom;
      mem_ready  = rdy;
      mem_rdata  = in_fill ? mem_line(fill_blk) : {4{$urandom}};
      cur_rst    = rst;
      cur_rd     = rd;
      cur_addr   = addr;
      cur_ready  = rdy;
      e.stall    = in_fill || (rd && !resident.exists(addr[29:2]));
      e.chk_data = rd && !e.stall;
      e.rdata    = mem_word(addr[29:2], int'(addr[1:0]));
      e.mrd      = in_fill;
      e.maddr    = exp_maddr;
      exp_q.push_back(e);
   endtask

   initial begin
      logic [29:0] a;
      logic [27:0] b;
      repeat (2) cycle(1'b0, 1'b0, 30'h0);
      // Cold miss with 3-cycle memory, then hits on the rest of the line.
      lat_cfg = 3;
      repeat (7) cycle(1'b1, 1'b1, 30'h10);
      cycle(1'b1, 1'b1, 30'h11);
      cycle(1'b1, 1'b1, 30'h12);
      cycle(1'b1, 1'b1, 30'h13);
      // Conflict on the same index, then the evicted line misses again.
      repeat (7) cycle(1'b1, 1'b1, 30'h30);
      repeat (7) cycle(1'b1, 1'b1, 30'h10);
      // Redirect during a fill.
      cycle(1'b1, 1'b0, 30'h0);
      cycle(1'b1, 1'b1, 30'h50);
      repeat (12) cycle(1'b1, 1'b1, 30'h44);
      repeat (3) cycle(1'b1, 1'b1, 30'h52);
      // Reset while a fill is outstanding, then the same address misses.
      cycle(1'b1, 1'b1, 30'h90);
      cycle(1'b1, 1'b1, 30'h90);
      cycle(1'b0, 1'b1, 30'h90);
      repeat (7) cycle(1'b1, 1'b1, 30'h90);
      // Zero-latency memory.
      lat_cfg = 0;
      repeat (4) cycle(1'b1, 1'b1, 30'hA4);
      // Randomized traffic with redirects, idle mem_ready noise and occasional resets.
      idle_noise = 1'b1;
      a = 30'h10;
      for (int i = 0; i < 3000; i++) begin
         lat_cfg = $urandom_range(0, 4);
         if ($urandom % 4 == 0) begin
            b = 28'($urandom_range(0, 23));
            if ($urandom % 16 == 0) b = b | 28'h0AB_0000;
            a = {b, 2'($urandom)};
         end else begin
            a = a + 30'd1;
         end
         cycle(($urandom % 150) != 0, ($urandom % 5) != 0, a);
      end
      repeat (2) @(posedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
